// File: rtl/reorder_buffer_commit.sv
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
// In-order commit ROB: rename allocates at tail, execution completes any entry, head retires when done.
// Commit pulse one cycle after the head's completion edge; rename stalls on rob_full; flush discards all.
module reorder_buffer_commit #(
    parameter int ROB_DEPTH = 16,
    parameter int TAG_WIDTH = $clog2(ROB_DEPTH)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flush,
    input  logic                               alloc_valid,
    input  logic                               alloc_has_write,
    input  logic [`PHYSICAL_REG_NUM_WIDTH-1:0] alloc_phy_dst,
    input  logic                               alloc_is_branch,
    output logic [TAG_WIDTH-1:0]               alloc_tag,
    output logic                               rob_full,
    output logic                               rob_empty,
    input  logic                               cmpl_valid,
    input  logic [TAG_WIDTH-1:0]               cmpl_tag,
    input  logic [`REG_VAL_WIDTH-1:0]          cmpl_val,
    input  logic                               cmpl_branch_taken,
    output logic                               commit_valid,
    output logic                               commit_with_write,
    output logic [`PHYSICAL_REG_NUM_WIDTH-1:0] commited_wr_register,
    output logic [`REG_VAL_WIDTH-1:0]          commit_wr_val,
    output logic                               commit_is_branch,
    output logic                               commit_branch_taken
);
    typedef struct packed {
        logic                               valid;
        logic                               done;
        logic                               has_write;
        logic [`PHYSICAL_REG_NUM_WIDTH-1:0] phy_dst;
        logic                               is_branch;
        logic                               taken;
        logic [`REG_VAL_WIDTH-1:0]          value;
    } entry_t;

    localparam logic [TAG_WIDTH:0]   FULL_COUNT = (TAG_WIDTH+1)'(ROB_DEPTH);
    localparam logic [TAG_WIDTH:0]   COUNT_ONE  = (TAG_WIDTH+1)'(1);
    localparam logic [TAG_WIDTH-1:0] PTR_ONE    = TAG_WIDTH'(1);

    entry_t               rob [ROB_DEPTH];
    entry_t               head_entry;
    logic [TAG_WIDTH-1:0] head;
    logic [TAG_WIDTH-1:0] tail;
    logic [TAG_WIDTH:0]   count;
    logic                 alloc_fire;
    logic                 cmpl_fire;
    logic                 commit_fire;

    // Full is judged on the registered count, so a same-cycle commit never frees a slot early.
    assign rob_full    = (count == FULL_COUNT);
    assign rob_empty   = (count == '0);
    assign alloc_tag   = tail;
    assign head_entry  = rob[head];
    assign alloc_fire  = alloc_valid && !rob_full && !flush;
    assign cmpl_fire   = cmpl_valid && rob[cmpl_tag].valid && !flush;
    assign commit_fire = head_entry.valid && head_entry.done && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rob[i] <= '0;
            end
            head                 <= '0;
            tail                 <= '0;
            count                <= '0;
            commit_valid         <= 1'b0;
            commit_with_write    <= 1'b0;
            commited_wr_register <= '0;
            commit_wr_val        <= '0;
            commit_is_branch     <= 1'b0;
            commit_branch_taken  <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rob[i].valid <= 1'b0;
                rob[i].done  <= 1'b0;
            end
            head                 <= '0;
            tail                 <= '0;
            count                <= '0;
            commit_valid         <= 1'b0;
            commit_with_write    <= 1'b0;
            commited_wr_register <= '0;
            commit_wr_val        <= '0;
            commit_is_branch     <= 1'b0;
            commit_branch_taken  <= 1'b0;
        end else begin
            commit_valid         <= commit_fire;
            commit_with_write    <= commit_fire && head_entry.has_write;
            commited_wr_register <= commit_fire ? head_entry.phy_dst : '0;
            commit_wr_val        <= commit_fire ? head_entry.value : '0;
            commit_is_branch     <= commit_fire && head_entry.is_branch;
            commit_branch_taken  <= commit_fire && head_entry.is_branch && head_entry.taken;

            if (cmpl_fire) begin
                rob[cmpl_tag].done  <= 1'b1;
                rob[cmpl_tag].value <= cmpl_val;
                rob[cmpl_tag].taken <= cmpl_branch_taken;
            end
            if (commit_fire) begin
                rob[head].valid <= 1'b0;
                rob[head].done  <= 1'b0;
                head            <= head + PTR_ONE;
            end
            // tail==head only when empty (no commit) or full (no alloc), so this never collides with the commit clear.
            if (alloc_fire) begin
                rob[tail] <= entry_t'{valid:     1'b1,
                                      done:      1'b0,
                                      has_write: alloc_has_write,
                                      phy_dst:   alloc_phy_dst,
                                      is_branch: alloc_is_branch,
                                      taken:     1'b0,
                                      value:     '0};
                tail      <= tail + PTR_ONE;
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_reorder_buffer_commit.sv
`timescale 1ns/1ps
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
// Directed bench for reorder_buffer_commit with a reference model and an expected-commit queue.
module tb_reorder_buffer_commit;
    localparam int D  = 16;
    localparam int TW = 4;
    localparam int PW = `PHYSICAL_REG_NUM_WIDTH;
    localparam int VW = `REG_VAL_WIDTH;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          alloc_valid = 1'b0;
    logic          alloc_has_write = 1'b0;
    logic [PW-1:0] alloc_phy_dst = '0;
    logic          alloc_is_branch = 1'b0;
    logic [TW-1:0] alloc_tag;
    logic          rob_full;
    logic          rob_empty;
    logic          cmpl_valid = 1'b0;
    logic [TW-1:0] cmpl_tag = '0;
    logic [VW-1:0] cmpl_val = '0;
    logic          cmpl_branch_taken = 1'b0;
    logic          commit_valid;
    logic          commit_with_write;
    logic [PW-1:0] commited_wr_register;
    logic [VW-1:0] commit_wr_val;
    logic          commit_is_branch;
    logic          commit_branch_taken;

    reorder_buffer_commit #(.ROB_DEPTH(D), .TAG_WIDTH(TW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_has_write(alloc_has_write),
        .alloc_phy_dst(alloc_phy_dst), .alloc_is_branch(alloc_is_branch),
        .alloc_tag(alloc_tag), .rob_full(rob_full), .rob_empty(rob_empty),
        .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag), .cmpl_val(cmpl_val),
        .cmpl_branch_taken(cmpl_branch_taken),
        .commit_valid(commit_valid), .commit_with_write(commit_with_write),
        .commited_wr_register(commited_wr_register), .commit_wr_val(commit_wr_val),
        .commit_is_branch(commit_is_branch), .commit_branch_taken(commit_branch_taken)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          hw;
        logic [PW-1:0] dst;
        logic [VW-1:0] val;
        logic          br;
        logic          tk;
    } exp_t;

    exp_t          q[$];
    int            checks = 0;
    int            errors = 0;
    bit            m_valid [D];
    bit            m_done  [D];
    bit            m_hw    [D];
    bit            m_br    [D];
    bit            m_tk    [D];
    logic [PW-1:0] m_dst   [D];
    logic [VW-1:0] m_val   [D];
    logic [TW-1:0] m_head;
    logic [TW-1:0] m_tail;
    int            m_count;
    logic [TW-1:0] t0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < D; i++) begin
            m_valid[i] = 0;
            m_done[i]  = 0;
        end
        m_head  = '0;
        m_tail  = '0;
        m_count = 0;
    endtask

    task automatic chk_zero_commit(input string tag);
        chk({tag, "_commit_valid"}, commit_valid, 0);
        chk({tag, "_with_write"}, commit_with_write, 0);
        chk({tag, "_wr_register"}, commited_wr_register, 0);
        chk({tag, "_wr_val"}, commit_wr_val, 0);
        chk({tag, "_is_branch"}, commit_is_branch, 0);
        chk({tag, "_branch_taken"}, commit_branch_taken, 0);
    endtask

    // One clock: predict from pre-edge model state, advance the model, then compare at edge+1.
    task automatic cyc();
        bit   a, c, k;
        exp_t e;
        a = alloc_valid && (m_count != D) && !flush;
        c = cmpl_valid && m_valid[cmpl_tag] && !flush;
        k = m_valid[m_head] && m_done[m_head] && !flush;
        if (k) q.push_back(exp_t'{hw: m_hw[m_head], dst: m_dst[m_head], val: m_val[m_head],
                                  br: m_br[m_head], tk: m_tk[m_head] & m_br[m_head]});
        @(posedge clk);
        if (flush) begin
            m_reset();
        end else begin
            if (c) begin
                m_done[cmpl_tag] = 1;
                m_val[cmpl_tag]  = cmpl_val;
                m_tk[cmpl_tag]   = cmpl_branch_taken;
            end
            if (k) begin
                m_valid[m_head] = 0;
                m_done[m_head]  = 0;
                m_head          = m_head + 1'b1;
            end
            if (a) begin
                m_valid[m_tail] = 1;
                m_done[m_tail]  = 0;
                m_hw[m_tail]    = alloc_has_write;
                m_dst[m_tail]   = alloc_phy_dst;
                m_br[m_tail]    = alloc_is_branch;
                m_tk[m_tail]    = 0;
                m_tail          = m_tail + 1'b1;
            end
            m_count = m_count + int'(a) - int'(k);
        end
        #1;
        chk("commit_valid", commit_valid, k);
        if (k) begin
            e = q.pop_front();
            chk("commit_with_write", commit_with_write, e.hw);
            chk("commited_wr_register", commited_wr_register, e.dst);
            chk("commit_wr_val", commit_wr_val, e.val);
            chk("commit_is_branch", commit_is_branch, e.br);
            chk("commit_branch_taken", commit_branch_taken, e.tk);
        end else begin
            chk_zero_commit("idle");
        end
        chk("alloc_tag", alloc_tag, m_tail);
        chk("rob_full", rob_full, m_count == D);
        chk("rob_empty", rob_empty, m_count == 0);
    endtask

    task automatic clear_inputs();
        flush       = 0;
        alloc_valid = 0;
        cmpl_valid  = 0;
    endtask

    task automatic alloc(input int dst, input bit hw, input bit br);
        clear_inputs();
        alloc_valid     = 1;
        alloc_phy_dst   = PW'(dst);
        alloc_has_write = hw;
        alloc_is_branch = br;
        cyc();
        alloc_valid = 0;
    endtask

    task automatic cmpl(input int tag, input int val, input bit tk);
        clear_inputs();
        cmpl_valid        = 1;
        cmpl_tag          = TW'(tag);
        cmpl_val          = VW'(val);
        cmpl_branch_taken = tk;
        cyc();
        cmpl_valid = 0;
    endtask

    task automatic idle(input int n);
        clear_inputs();
        repeat (n) cyc();
    endtask

    initial begin
        m_reset();
        #1 reset = 1;
        #1;
        chk("rst_rob_empty", rob_empty, 1);
        chk("rst_rob_full", rob_full, 0);
        chk("rst_alloc_tag", alloc_tag, 0);
        chk_zero_commit("rst");
        @(negedge clk) reset = 0;

        // In order commit despite completions arriving 2,0,1.
        alloc(5, 1, 0);
        alloc(6, 1, 0);
        alloc(7, 1, 0);
        cmpl(2, 'h22, 0);
        cmpl(0, 'h00, 0);
        cmpl(1, 'h11, 0);
        idle(3);

        // Branch with no destination write, taken.
        alloc(3, 0, 1);
        cmpl(3, 'h0, 1);
        idle(2);

        // Completion to an unallocated tag.
        cmpl(9, 'hdead, 1);
        idle(2);

        // Flush beats a pending commit, an allocation and a completion.
        alloc(10, 1, 0);
        alloc(11, 1, 0);
        alloc(12, 1, 0);
        alloc(13, 1, 0);
        cmpl(4, 'h44, 0);
        flush = 1; alloc_valid = 1; alloc_phy_dst = 6'd20; cmpl_valid = 1; cmpl_tag = 4'd5; cmpl_val = 'h55;
        cyc();
        clear_inputs();
        chk("flush_alloc_tag", alloc_tag, 0);
        chk("flush_empty", rob_empty, 1);

        // Fill, overfill, free one slot and wrap the tail back to tag 0.
        for (int i = 0; i < D; i++) alloc(i + 8, 1, 0);
        chk("full_flag", rob_full, 1);
        alloc(63, 1, 0);
        alloc_valid = 1; alloc_phy_dst = 6'd50; cmpl_valid = 1; cmpl_tag = 4'd0; cmpl_val = 'ha0;
        cyc();
        cmpl_valid = 0; alloc_phy_dst = 6'd51;
        cyc();
        alloc_valid = 0;
        chk("wrap_alloc_tag", alloc_tag, 0);
        alloc(40, 1, 0);
        cmpl(0, 'h400, 0);
        for (int t = D - 1; t >= 1; t--) cmpl(t, t * 16 + 1, 0);
        idle(18);

        // Asynchronous reset between edges right after a commit pulse.
        t0 = m_tail;
        for (int i = 0; i < 5; i++) alloc(30 + i, 1, 0);
        cmpl(int'(t0), 'h55, 0);
        idle(1);
        #3 reset = 1;
        #1;
        chk("arst_rob_empty", rob_empty, 1);
        chk("arst_rob_full", rob_full, 0);
        chk("arst_alloc_tag", alloc_tag, 0);
        chk_zero_commit("arst");
        m_reset();
        q.delete();
        @(posedge clk);
        #1;
        chk("arst_hold_empty", rob_empty, 1);
        chk_zero_commit("arst_hold");
        @(negedge clk) reset = 0;
        alloc(9, 1, 0);
        cmpl(0, 'h99, 0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reorder_buffer_commit.md
REORDER_BUFFER_COMMIT -- requirements
Module: reorder_buffer_commit

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 16, number of entries (power of two, >=4).
REQ-002 SHALL have parameter TAG_WIDTH, default $clog2(ROB_DEPTH), entry tag width.
REQ-003 SHALL have one clock and an asynchronous active-high reset. Ports: clk, input, 1, rising-edge clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port flush, input, 1, discard all in-flight entries.
REQ-006 SHALL have port alloc_valid, input, 1, rename requests an entry.
REQ-007 SHALL have port alloc_has_write, input, 1, instruction writes a destination register.
REQ-008 SHALL have port alloc_phy_dst, input, `PHYSICAL_REG_NUM_WIDTH, renamed destination.
REQ-009 SHALL have port alloc_is_branch, input, 1, instruction is a conditional branch.
REQ-010 SHALL have port alloc_tag, output, TAG_WIDTH, tag of the entry the current request receives (equals tail).
REQ-011 SHALL have port rob_full, output, 1, count==ROB_DEPTH; rename stalls on it.
REQ-012 SHALL have port rob_empty, output, 1, count==0.
REQ-013 SHALL have port cmpl_valid, input, 1, an execution unit finished an entry.
REQ-014 SHALL have port cmpl_tag, input, TAG_WIDTH, finished entry.
REQ-015 SHALL have port cmpl_val, input, `REG_VAL_WIDTH, result value.
REQ-016 SHALL have port cmpl_branch_taken, input, 1, resolved branch direction.
REQ-017 SHALL have the following registered commit outputs: commit_valid (1), commit_with_write (1), commited_wr_register (`PHYSICAL_REG_NUM_WIDTH), commit_wr_val (`REG_VAL_WIDTH), commit_is_branch (1), commit_branch_taken (1).

Function
REQ-018 SHALL hold per entry: valid, done, has_write, phy_dst, is_branch, taken, value. It SHALL also hold head and tail pointers (TAG_WIDTH) and count (TAG_WIDTH+1).
REQ-019 SHALL accept an allocation at a clock edge iff alloc_valid && !rob_full && !flush. The accepted allocation writes the entry at tail with valid=1 and done=0, increments tail modulo ROB_DEPTH, and increments count.
REQ-020 SHALL evaluate rob_full on the registered count only. When full, a commit in the same cycle SHALL NOT admit an allocation.
REQ-021 SHALL, on cmpl_valid with entry[cmpl_tag].valid==1, set done=1 and store value and taken at the edge. A completion to an invalid entry SHALL be ignored with no state change.
REQ-022 SHALL commit at an edge iff entry[head].valid && entry[head].done && !flush. The commit SHALL:
- register commit_valid=1;
- register commit_with_write=has_write, commited_wr_register=phy_dst, commit_wr_val=value;
- register commit_is_branch=is_branch, commit_branch_taken=taken&is_branch;
- clear entry valid, advance head modulo ROB_DEPTH, and decrement count.
REQ-023 SHALL commit at most one entry per cycle, strictly in allocation order. Out-of-order completion SHALL never reorder commits.
REQ-024 SHALL drive all commit outputs to 0 in any cycle following an edge with no commit, so that commit outputs are single-cycle pulses.
REQ-025 SHALL have a latency, from the completion edge of the head entry to the commit_valid pulse, of exactly one cycle. A completion and a head check in the same cycle SHALL use the pre-edge done value.
REQ-026 SHALL allow allocation and commit in the same cycle, leaving count unchanged; tail and head SHALL each advance.
REQ-027 SHALL give flush priority over allocation, completion and commit. Flush SHALL clear all valid and done bits, set head=tail=count=0, and zero the commit outputs at that edge.
REQ-028 SHALL wrap pointers at ROB_DEPTH. Tags SHALL be reused after wrap-around without corrupting older entries.

Reset
REQ-029 SHALL, on reset assertion at any time including mid-operation, immediately clear head, tail, count, all valid and done bits, and all commit outputs.
REQ-030 SHALL present the following values during and after reset: rob_empty=1, rob_full=0, alloc_tag=0, and all commit outputs 0.

Verification
REQ-031 Reset test: assert reset asynchronously between edges with 5 entries pending -> outputs are 0 within the same cycle, rob_empty=1, alloc_tag=0.
REQ-032 In-order commit test: allocate 3 entries with dst 5,6,7 (tags 0,1,2), then complete them in order 2,0,1 with values 0x22,0x00,0x11 -> commits occur on consecutive cycles with commited_wr_register 5,6,7 and commit_wr_val 0x00,0x11,0x22.
REQ-033 Full and wrap test: allocate 16 entries -> rob_full=1 and a 17th request is ignored. Complete and commit tag 0 -> rob_full=0, the next allocation receives alloc_tag=0, and it commits after tags 1..15.
REQ-034 Branch commit test: allocate a branch (alloc_has_write=0) and complete it with cmpl_branch_taken=1 -> one cycle later commit_valid=1, commit_is_branch=1, commit_branch_taken=1, commit_with_write=0.
REQ-035 Flush test: flush with 4 pending entries while alloc_valid=1 and cmpl_valid=1 -> count=0, no commit pulse, and the next allocation gets tag 0.
REQ-036 Stale completion test: cmpl_valid to an unallocated tag 9 -> no state change and no commit.
